// File: rtl/booth_bcd_out_if.sv
// ---------------------------------------------------------------------------
// booth_bcd_out_if
// Bundle between the Booth multiplier (master) and the binary-to-BCD readout
// stage (slave).
//   Y        master->slave  2N-bit product
//   y_valid  master->slave  one-cycle "product ready" strobe
//   busy     slave->master  conversion in progress
//   done     slave->master  one-cycle pulse, bcd/sign just updated
//   bcd      slave->master  4*DIGITS-bit result, digit 0 in [3:0]
//   sign     slave->master  1 = negative product
//   overrun  slave->master  sticky: a strobe arrived while busy and was dropped
// ---------------------------------------------------------------------------
interface booth_bcd_out_if #(
  parameter int N      = 8,
  parameter int DIGITS = 5
);
  logic [2*N-1:0]      Y;
  logic                y_valid;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                sign;
  logic                overrun;

  modport master (output Y, y_valid, input busy, done, bcd, sign, overrun);
  modport slave  (input Y, y_valid, output busy, done, bcd, sign, overrun);
endinterface

// File: rtl/booth_bcd_out.sv
// ---------------------------------------------------------------------------
// booth_bcd_out
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) for
// the 2N-bit Booth product. A y_valid strobe in IDLE captures the product
// magnitude; 2N shift cycles later bcd/sign are loaded and done pulses.
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous, active-high reset
//   bus  booth_bcd_out_if.slave (Y, y_valid in; busy, done, bcd, sign,
//        overrun out). All outputs come straight from registers.
//
// Build option: define BOOTH_BCD_SIGNED_EN to treat Y as two's complement
// (sign = Y MSB, magnitude = |Y|). Without it Y is unsigned and sign is 0.
// ---------------------------------------------------------------------------
module booth_bcd_out #(
  parameter int N      = 8,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  booth_bcd_out_if.slave bus
);
  localparam int W     = 2 * N;
  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q,   state_d;
  logic [W-1:0]     shreg_q,   shreg_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [BW-1:0]    bcd_q,     bcd_d;
  logic             overrun_q, overrun_d;
  logic [W-1:0]     mag;

  // Per-nibble add-3; nibbles never carry into each other because a digit
  // of at most 9 plus 3 stays within 4 bits.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BOOTH_BCD_SIGNED_EN
  logic sign_cap_q, sign_cap_d;
  logic sign_q,     sign_d;
  // 0x8000 negates to 0x8000, which read as unsigned is the right magnitude.
  assign mag      = bus.Y[W-1] ? W'(-bus.Y) : bus.Y;
  assign bus.sign = sign_q;
`else
  assign mag      = bus.Y;
  assign bus.sign = 1'b0;
`endif

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd     = bcd_q;
  assign bus.overrun = overrun_q;

  // NOTE: every _d signal takes a default (its _q) before the case; a path
  // that skipped an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    overrun_d = overrun_q;
`ifdef BOOTH_BCD_SIGNED_EN
    sign_cap_d = sign_cap_q;
    sign_d     = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.y_valid) begin
          shreg_d   = mag;
          scratch_d = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
`ifdef BOOTH_BCD_SIGNED_EN
          sign_cap_d = bus.Y[W-1];
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.y_valid) overrun_d = 1'b1;
        {scratch_d, shreg_d} = {add3(scratch_q), shreg_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bcd_d   = scratch_d;
`ifdef BOOTH_BCD_SIGNED_EN
          sign_d  = sign_cap_q;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.y_valid) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      overrun_q <= 1'b0;
`ifdef BOOTH_BCD_SIGNED_EN
      sign_cap_q <= 1'b0;
      sign_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      overrun_q <= overrun_d;
`ifdef BOOTH_BCD_SIGNED_EN
      sign_cap_q <= sign_cap_d;
      sign_q     <= sign_d;
`endif
    end
  end
endmodule

// File: tb/tb_booth_bcd_out.sv
// ---------------------------------------------------------------------------
// tb_booth_bcd_out
// Directed and random conversions checked against a decimal reference model
// (repeated division by 10 of |Y|). Works for both the signed and unsigned
// build (BOOTH_BCD_SIGNED_EN). Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_booth_bcd_out;
  localparam int N      = 8;
  localparam int DIGITS = 5;
  localparam int W      = 2 * N;
  localparam int LAT    = W + 1;   // falling edges from the capture edge to done

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  booth_bcd_out_if #(.N(N), .DIGITS(DIGITS)) bus ();
  booth_bcd_out #(.N(N), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_sign(input logic [W-1:0] y);
`ifdef BOOTH_BCD_SIGNED_EN
    return y[W-1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [W-1:0] y);
    int m;
    logic [4*DIGITS-1:0] r;
    m = int'(y);
    if (ref_sign(y)) m = (1 << W) - m;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Waits for done starting at falling edge index 'from'; returns the index
  // at which done was seen, or 0 if the bound expired.
  task automatic wait_done(input int from, output int idx);
    idx = 0;
    for (int i = from; i < 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        idx = i;
        break;
      end
    end
  endtask

  // Starts and finishes one conversion; called on a falling edge, returns on
  // the falling edge after done.
  task automatic do_conv(input logic [W-1:0] y);
    int idx;
    bus.Y = y; bus.y_valid = 1'b1;
    @(negedge clk);
    bus.y_valid = 1'b0;
    check("busy_after_capture", 32'(bus.busy), 32'd1);
    check("overrun_cleared", 32'(bus.overrun), 32'd0);
    wait_done(2, idx);
    check("done_latency", 32'(idx), 32'(LAT));
    check("bcd", 32'(bus.bcd), 32'(ref_bcd(y)));
    check("sign", 32'(bus.sign), 32'(ref_sign(y)));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_dropped", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int idx;
    int done_seen;
    bus.Y = '0; bus.y_valid = 1'b0;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    check("rst_sign", 32'(bus.sign), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed values, including the sign boundaries
    do_conv(16'd255);
    check("bcd_255_const", 32'(bus.bcd), 32'h00255);
    do_conv(16'hFF9C);
`ifdef BOOTH_BCD_SIGNED_EN
    check("bcd_m100_const", 32'(bus.bcd), 32'h00100);
`else
    check("bcd_65436_const", 32'(bus.bcd), 32'h65436);
`endif
    do_conv(16'h8000);
`ifdef BOOTH_BCD_SIGNED_EN
    check("sign_8000_const", 32'(bus.sign), 32'd1);
`endif
    check("bcd_8000_const", 32'(bus.bcd), 32'h32768);
    do_conv(16'h7FFF);
    check("bcd_7fff_const", 32'(bus.bcd), 32'h32767);
    do_conv(16'h0000);
    do_conv(16'hFFFF);

    // Overrun: second strobe five cycles after capture is dropped
    bus.Y = 16'd1234; bus.y_valid = 1'b1;
    @(negedge clk);
    bus.y_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.Y = 16'd9; bus.y_valid = 1'b1;
    @(negedge clk);
    bus.y_valid = 1'b0;
    check("overrun_set", 32'(bus.overrun), 32'd1);
    wait_done(7, idx);
    check("overrun_done_latency", 32'(idx), 32'(LAT));
    check("overrun_bcd", 32'(bus.bcd), 32'h01234);
    check("overrun_sticky", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    // Back-to-back accepted on the cycle after done; clears overrun
    do_conv(16'(32'($urandom)));

    // Reset in mid conversion aborts without a done pulse
    bus.Y = 16'd4321; bus.y_valid = 1'b1;
    @(negedge clk);
    bus.y_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    check("abort_sign", 32'(bus.sign), 32'd0);
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    do_conv(16'd7);
    check("bcd_7_const", 32'(bus.bcd), 32'h00007);

    // Random products
    for (int k = 0; k < 12; k++) do_conv(16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
